// File: rtl/truth_table_streamer_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_pkg : shared states, ASCII constants and digit-count helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package truth_table_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_APPLY   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_LOAD    = 3'd3,
      ST_DAVL    = 3'd4,
      ST_DAVH    = 3'd5,
      ST_NEXT    = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;

   function automatic int hex_digits(input int width);
      return (width + 3) / 4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_streamer_hex_ascii_enc.sv
// ---------------------------------------------------------------------------
// hex_ascii_enc : 4-bit nibble to uppercase ASCII hex character
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_ascii_enc (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
      else                ascii = 8'h37 + {4'h0, nibble};
   end

endmodule

`default_nettype wire

// File: rtl/truth_table_streamer.sv
// ---------------------------------------------------------------------------
// truth_table_streamer : exhaustive sweep of a combinational network, one
// ASCII row per vector streamed over the dav_/rfd handshake.
// Option macro ROW_CRLF_EN appends CR LF to every row.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module truth_table_streamer
   import truth_table_pkg::*;
#(
   parameter int IN_W   = 3,
   parameter int OUT_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic             start,
   output logic [IN_W-1:0]  in_comb,
   input  logic [OUT_W-1:0] out_comb,
   output logic [7:0]       data,
   output logic             dav_,
   input  logic             rfd,
   output logic             busy,
   output logic             done
);

   localparam int c_id      = hex_digits(IN_W);
   localparam int c_od      = hex_digits(OUT_W);
   localparam int c_in_ext  = 4 * c_id;
   localparam int c_out_ext = 4 * c_od;
`ifdef ROW_CRLF_EN
   localparam int c_row_len = c_id + c_od + 3;
`else
   localparam int c_row_len = c_id + c_od + 1;
`endif
   localparam int                 c_idx_w       = $clog2(c_row_len);
   localparam logic [c_idx_w-1:0] c_idx_last    = c_idx_w'(c_row_len - 1);
   localparam logic [3:0]         c_settle_last = 4'(SETTLE - 1);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [IN_W-1:0]        r_in_comb;
   logic [c_out_ext-1:0]   r_row_out;
   logic [c_idx_w-1:0]     r_idx;
   logic [3:0]             r_settle;
   logic [7:0]             r_data;
   logic                   r_dav_n;
   logic                   r_busy;
   logic                   r_done;

   logic [c_in_ext-1:0]    w_in_ext;
   logic [3:0]             w_nibble;
   logic                   w_is_hex;
   logic [7:0]             w_lit;
   logic [7:0]             w_hex_char;
   logic [7:0]             w_char;

   assign w_in_ext = c_in_ext'(r_in_comb);

   // Character select: input digits, colon, output digits, optional CR LF
   always_comb begin
      w_nibble = 4'h0;
      w_is_hex = 1'b1;
      w_lit    = CHAR_COLON;
      for (int k = 0; k < c_id; k++) begin
         if (int'(r_idx) == k) w_nibble = w_in_ext[4*(c_id-1-k) +: 4];
      end
      for (int k = 0; k < c_od; k++) begin
         if (int'(r_idx) == c_id + 1 + k) w_nibble = r_row_out[4*(c_od-1-k) +: 4];
      end
      if (int'(r_idx) == c_id) w_is_hex = 1'b0;
`ifdef ROW_CRLF_EN
      if (int'(r_idx) == c_id + c_od + 1) begin
         w_is_hex = 1'b0;
         w_lit    = CHAR_CR;
      end
      if (int'(r_idx) == c_id + c_od + 2) begin
         w_is_hex = 1'b0;
         w_lit    = CHAR_LF;
      end
`endif
   end

   hex_ascii_enc u_hex_ascii_enc (
      .nibble (w_nibble),
      .ascii  (w_hex_char)
   );

   assign w_char = w_is_hex ? w_hex_char : w_lit;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start) w_state_next = ST_APPLY;
         ST_APPLY:         if (r_settle == c_settle_last) w_state_next = ST_CAPTURE;
         ST_CAPTURE:       w_state_next = ST_LOAD;
         ST_LOAD:          w_state_next = ST_DAVL;
         // Leave only once dav_ has actually been seen low by the consumer
         ST_DAVL:          if (!rfd && !r_dav_n) w_state_next = ST_DAVH;
         ST_DAVH:          if (rfd) w_state_next = ST_NEXT;
         ST_NEXT: begin
            if (r_idx != c_idx_last) w_state_next = ST_LOAD;
            else if (&r_in_comb)     w_state_next = ST_DONE;
            else                     w_state_next = ST_APPLY;
         end
         default:          w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_in_comb <= '0;
         r_row_out <= '0;
         r_idx     <= '0;
         r_settle  <= '0;
         r_data    <= '0;
         r_dav_n   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_in_comb <= '0;
                  r_settle  <= '0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
               end
            end
            ST_APPLY:   r_settle <= r_settle + 4'd1;
            ST_CAPTURE: begin
               r_row_out <= c_out_ext'(out_comb);
               r_idx     <= '0;
            end
            ST_LOAD:    r_data <= w_char;
            // dav_ drops one cycle after data settles, rises on the ack
            ST_DAVL:    r_dav_n <= (!rfd && !r_dav_n);
            ST_NEXT: begin
               if (r_idx != c_idx_last) begin
                  r_idx <= r_idx + 1'b1;
               end else if (&r_in_comb) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end else begin
                  r_in_comb <= r_in_comb + 1'b1;
                  r_settle  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_comb = r_in_comb;
   assign data    = r_data;
   assign dav_    = r_dav_n;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

`default_nettype wire
